// File: rtl/text_render_ctrl_pkg.sv
// Shared definitions for the text overlay renderer.
// Contents: glyph cell geometry, the reserved blank code, the highest letter
// code, buffer address/code widths, FSM state encoding and a letter test.
package text_render_ctrl_pkg;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;
  localparam int ADDR_W  = 4;
  localparam int CODE_W  = 5;

  localparam logic [CODE_W-1:0] BLANK_CODE  = 5'd31;
  localparam logic [CODE_W-1:0] LAST_LETTER = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Codes above the last letter render as blank cells.
  function automatic logic is_letter(input logic [CODE_W-1:0] code);
    return code <= LAST_LETTER;
  endfunction

endpackage

// File: rtl/text_render_ctrl_text_buffer.sv
// Double-buffered character storage for the text line.
// The host writes into the shadow buffer at any time; the active buffer that
// feeds the renderer is only replaced at a frame boundary so a line never
// tears mid-frame.
// Ports:
//   sys_clk, sys_rst      clock, asynchronous active-high reset
//   frame_start           frame boundary pulse, the only point a copy happens
//   wr_en/wr_addr/wr_char shadow write port (addresses past NUM_CHARS ignored)
//   commit                request a shadow->active copy at the next boundary
//   rd_addr/rd_char       combinational read of the active buffer
//   commit_done           one-cycle pulse the cycle after a copy
module text_buffer
  import text_render_ctrl_pkg::*;
#(
  parameter int NUM_CHARS = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CODE_W-1:0] wr_char,
  input  logic              commit,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CODE_W-1:0] rd_char,
  output logic              commit_done
);

  // One bit wider than the address so NUM_CHARS == 2**ADDR_W still compares.
  localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(NUM_CHARS);

  logic [CODE_W-1:0] shadow_q [NUM_CHARS];
  logic [CODE_W-1:0] active_q [NUM_CHARS];
  logic              pending_q;
  logic              done_q;
  logic              copy_d;

  // A commit arriving on the boundary cycle itself is honoured immediately.
  assign copy_d = frame_start & (pending_q | commit);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        shadow_q[i] <= BLANK_CODE;
        active_q[i] <= BLANK_CODE;
      end
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (wr_en && ({1'b0, wr_addr} < CELLS)) begin
        shadow_q[wr_addr] <= wr_char;
      end
      // Non-blocking copy reads the pre-write shadow, so a same-cycle write
      // lands only in shadow.
      if (copy_d) begin
        for (int i = 0; i < NUM_CHARS; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (copy_d) begin
        pending_q <= 1'b0;
      end else if (commit) begin
        pending_q <= 1'b1;
      end
      done_q <= copy_d;
    end
  end

  always_comb begin
    rd_char = BLANK_CODE;
    if ({1'b0, rd_addr} < CELLS) begin
      rd_char = active_q[rd_addr];
    end
  end

  assign commit_done = done_q;

endmodule

// File: rtl/text_render_ctrl.sv
// Single-line text overlay controller.
// Maps the scan position onto a box of NUM_CHARS 16x16 glyph cells, looks up
// the character for the current cell, drives an external glyph ROM and turns
// its bit into a foreground pixel two cycles after the scan position.
// Ports:
//   sys_clk, sys_rst            pixel clock, asynchronous active-high reset
//   enable, frame_start         render request and frame boundary pulse
//   pix_x, pix_y                current scan position
//   wr_en, wr_addr, wr_char     character write into the shadow buffer
//   commit / commit_done        buffer swap request and its completion pulse
//   glyph_char/x/y, glyph_bit   external glyph lookup (bit is combinational)
//   text_pixel, text_on         foreground pixel and in-box flag
module text_render_ctrl
  import text_render_ctrl_pkg::*;
#(
  parameter logic [9:0] ORIGIN_X  = 10'd256,
  parameter logic [9:0] ORIGIN_Y  = 10'd232,
  parameter int         NUM_CHARS = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CODE_W-1:0] wr_char,
  input  logic              commit,
  output logic [CODE_W-1:0] glyph_char,
  output logic [3:0]        glyph_x,
  output logic [3:0]        glyph_y,
  input  logic              glyph_bit,
  output logic              text_pixel,
  output logic              text_on,
  output logic              commit_done
);

  // Box limits in 11 bits so the right edge (up to 1023+256) cannot overflow.
  localparam logic [10:0] X0 = {1'b0, ORIGIN_X};
  localparam logic [10:0] Y0 = {1'b0, ORIGIN_Y};
  localparam logic [10:0] X1 = X0 + 11'(GLYPH_W * NUM_CHARS);
  localparam logic [10:0] Y1 = Y0 + 11'(GLYPH_H);

  state_e            state_q;
  logic [10:0]       px_d, py_d, dx_d, dy_d;
  logic              in_box_d;
  logic [CODE_W-1:0] cell_char_d;
  logic [CODE_W-1:0] glyph_char_q;
  logic [3:0]        glyph_x_q, glyph_y_q;
  logic              in_box_p1_q, run_p1_q;
  logic              text_pixel_q, text_on_q;

  text_buffer #(
    .NUM_CHARS (NUM_CHARS)
  ) u_buf (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_char     (wr_char),
    .commit      (commit),
    .rd_addr     (dx_d[ADDR_W+3:4]),
    .rd_char     (cell_char_d),
    .commit_done (commit_done)
  );

  // Offsets may wrap when left/above the box; the explicit range test below
  // keeps a wrapped offset from ever counting as inside.
  assign px_d     = {1'b0, pix_x};
  assign py_d     = {1'b0, pix_y};
  assign dx_d     = px_d - X0;
  assign dy_d     = py_d - Y0;
  assign in_box_d = (px_d >= X0) && (px_d < X1) && (py_d >= Y0) && (py_d < Y1);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (enable) state_q <= ST_ARMED;
        ST_ARMED: begin
          if (!enable)          state_q <= ST_IDLE;
          else if (frame_start) state_q <= ST_RUN;
        end
        // Once running, a frame always completes; stopping waits for a boundary.
        ST_RUN:   if (frame_start && !enable) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: glyph address and qualifiers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      glyph_char_q <= BLANK_CODE;
      glyph_x_q    <= 4'd0;
      glyph_y_q    <= 4'd0;
      in_box_p1_q  <= 1'b0;
      run_p1_q     <= 1'b0;
    end else begin
      glyph_char_q <= in_box_d ? cell_char_d : BLANK_CODE;
      glyph_x_q    <= dx_d[3:0];
      glyph_y_q    <= dy_d[3:0];
      in_box_p1_q  <= in_box_d;
      run_p1_q     <= (state_q == ST_RUN);
    end
  end

  // Stage 2: pixel from the external glyph bit
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      text_pixel_q <= 1'b0;
      text_on_q    <= 1'b0;
    end else begin
      text_on_q    <= in_box_p1_q & run_p1_q;
      text_pixel_q <= glyph_bit & in_box_p1_q & run_p1_q & is_letter(glyph_char_q);
    end
  end

  assign glyph_char = glyph_char_q;
  assign glyph_x    = glyph_x_q;
  assign glyph_y    = glyph_y_q;
  assign text_pixel = text_pixel_q;
  assign text_on    = text_on_q;

endmodule

// File: doc/text_render_ctrl.md
TEXT_RENDER_CTRL -- requirements
Module: text_render_ctrl

Interface
REQ-001 SHALL have parameter ORIGIN_X, default 10'd256: left pixel column of the text box.
REQ-002 SHALL have parameter ORIGIN_Y, default 10'd232: top pixel row of the text box.
REQ-003 SHALL have parameter NUM_CHARS, default 16: character cells in the single text line.
REQ-004 SHALL have port sys_clk, input, 1: pixel clock; all state on the rising edge.
REQ-005 SHALL have port sys_rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port enable, input, 1: rendering request; sampled only at frame_start.
REQ-007 SHALL have port frame_start, input, 1: one-cycle pulse at the first pixel of each frame.
REQ-008 SHALL have port pix_x, input, 10: current scan column.
REQ-009 SHALL have port pix_y, input, 10: current scan row.
REQ-010 SHALL have port wr_en, input, 1: shadow-buffer write strobe.
REQ-011 SHALL have port wr_addr, input, 4: cell index.
REQ-012 SHALL have port wr_char, input, 5: glyph code (0-25 letters; 26-31 blank).
REQ-013 SHALL have port commit, input, 1: request to copy the shadow buffer to the active buffer.
REQ-014 SHALL have port glyph_char, output, 5: glyph code to the glyph lookup.
REQ-015 SHALL have port glyph_x, output, 4: column within the glyph.
REQ-016 SHALL have port glyph_y, output, 4: row within the glyph.
REQ-017 SHALL have port glyph_bit, input, 1: glyph lookup result, combinational from glyph_* outputs.
REQ-018 SHALL have port text_pixel, output, 1: foreground pixel.
REQ-019 SHALL have port text_on, output, 1: pixel lies inside the text box.
REQ-020 SHALL have port commit_done, output, 1: one-cycle pulse when a commit is applied.

Function
REQ-021 SHALL run FSM states IDLE, ARMED, RUN: IDLE->ARMED on enable=1; ARMED->RUN on frame_start with enable=1; ARMED->IDLE on enable=0; RUN->IDLE only on frame_start with enable=0.
REQ-022 SHALL define the text box as ORIGIN_X <= pix_x < ORIGIN_X+16*NUM_CHARS and ORIGIN_Y <= pix_y < ORIGIN_Y+16.
REQ-023 SHALL, at stage 1, register glyph_x=(pix_x-ORIGIN_X)[3:0], glyph_y=(pix_y-ORIGIN_Y)[3:0], and glyph_char=active[(pix_x-ORIGIN_X)>>4]; it SHALL register glyph_char=31 when outside the box.
REQ-024 SHALL, at stage 2, register text_pixel=glyph_bit AND in_box_d1 AND RUN_d1 AND (glyph_char<26).
REQ-025 SHALL register text_on=in_box_d1 AND RUN_d1; text_on and text_pixel SHALL have a latency of exactly 2 cycles from pix_x/pix_y.
REQ-026 SHALL compute box arithmetic in 11 bits; pix_x < ORIGIN_X SHALL never wrap into the box.
REQ-027 SHALL write wr_char to shadow[wr_addr] on wr_en; wr_addr >= NUM_CHARS SHALL be ignored.
REQ-028 SHALL set commit_pending on commit; at frame_start with commit_pending or commit=1, active SHALL be loaded from shadow in one cycle, pending SHALL clear, and commit_done SHALL pulse the next cycle.
REQ-029 SHALL exclude a wr_en in the same cycle as a commit copy from that copy; the write SHALL land in shadow only.
REQ-030 SHALL keep repeated commits before frame_start as a single pending commit with a single commit_done.
REQ-031 SHALL apply commits in every FSM state, including IDLE.

Reset
REQ-032 SHALL, on sys_rst, go immediately to IDLE, fill both buffers with code 31, clear commit_pending, and drive text_pixel=0, text_on=0, commit_done=0, glyph_char=31, glyph_x=0, glyph_y=0.
REQ-033 SHALL, on reset mid-frame, abandon the frame; rendering SHALL resume only after enable and a new frame_start.

Structure
REQ-034 SHALL place in the shared text package: glyph width/height 16, BLANK_CODE 31, LAST_LETTER 25, and FSM state encodings.
REQ-035 SHALL contain one sub-module, text_buffer, holding shadow/active storage, the write port and the commit copy; the glyph lookup SHALL stay external.

Verification
REQ-036 SHALL verify: write "HELLO" (7,4,11,11,14) to cells 0-4, commit, frame_start with enable -> at pix_x=256, pix_y=232 glyph_char=7, text_pixel follows glyph_bit 2 cycles later.
REQ-037 SHALL verify: pix_x=255 or 512, pix_y=247 or 248 -> text_on=0 and glyph_char=31; pix_x=511, pix_y=247 -> text_on=1, glyph_x=15, glyph_y=15.
REQ-038 SHALL verify: commit and frame_start in the same cycle as wr_en to cell 0 (code 3) -> active[0] holds the old shadow value, shadow[0]=3, commit_done pulses once.
REQ-039 SHALL verify: enable dropped mid-frame -> rendering continues until the next frame_start, then text_on=0 for the whole frame.
REQ-040 SHALL verify: sys_rst asserted mid-line -> all outputs 0 or 31 asynchronously; after release, no output until enable plus frame_start.
REQ-041 SHALL verify: cell code 28 inside the box with glyph_bit forced 1 -> text_on=1, text_pixel=0.
